spi_master_ctrl: RTL and testbench

SPI mode 0 (CPOL=0, CPHA=0) master that drives the two-byte frame the FPGA-side SPI slave expects: a command byte followed by a data byte, under one SS assertion. Used on the test/controller side of the USB3300 sniffer link, and as a bench-side driver, to issue commands and collect the slave's status and data bytes. Generates SCK from `clk` through a programmable divider. Exposes a start/busy/done handshake to local logic.

---
 rtl/spi_master_ctrl.sv | 162 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode 0 master issuing a {command, data} two-byte frame under one SS assertion.
// Define SPI_MASTER_LOOPBACK_EN to feed the RX shifter from MOSI instead of the MISO pin.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] CMD_in,
  input  logic [7:0] DATA_in,
  output logic [7:0] STA_out,
  output logic [7:0] DATA_out,
  output logic       busy,
  output logic       done,
  output logic       SCK,
  output logic       SS,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       hp_q, hp_d;
  logic [15:0]      tx_q, tx_d;
  logic [15:0]      rx_q, rx_d;
  logic             sck_q, sck_d;
  logic             ss_q, ss_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       sta_q, sta_d;
  logic [7:0]       dout_q, dout_d;
  logic             tick;
  logic             rx_in;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic miso_unused;
  assign miso_unused = MISO;
  assign rx_in = mosi_q;
`else
  assign rx_in = MISO;
`endif

  // One tick per CLK_DIV cycles; every state change and SCK edge lands on a tick.
  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      hp_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sck_q   <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sta_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sck_q   <= sck_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sta_q   <= sta_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    hp_d    = hp_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sck_d   = sck_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sta_d   = sta_q;
    dout_d  = dout_q;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          tx_d    = {CMD_in, DATA_in};
          rx_d    = '0;
          hp_d    = '0;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = CMD_in[7];
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[14:0], rx_in};
          hp_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // hp even: falling edge, odd: rising edge; hp 31 closes the last low phase.
        if (tick) begin
          hp_d = hp_q + 5'd1;
          if (hp_q == 5'd31) begin
            state_d = HOLD;
          end else if (!hp_q[0]) begin
            sck_d  = 1'b0;
            tx_d   = {tx_q[14:0], 1'b0};
            mosi_d = tx_q[14];
          end else begin
            sck_d = 1'b1;
            rx_d  = {rx_q[14:0], rx_in};
          end
        end
      end
      HOLD: begin
        if (tick) begin
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          sta_d   = rx_q[15:8];
          dout_d  = rx_q[7:0];
          state_d = GAP;
        end
      end
      GAP: begin
        // Guarantees the slave sees a minimum SS-high time before the next frame.
        if (tick) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign STA_out  = sta_q;
  assign DATA_out = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign SCK      = sck_q;
  assign SS       = ss_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized scoreboard bench for spi_master_ctrl: frame-level reference model plus a
// back-to-back instance at CLK_DIV=2 with start held high.
module tb_spi_master_ctrl;
  localparam int D  = 4;
  localparam int D2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main DUT, CLK_DIV=4
  logic       rst, start, MISO;
  logic [7:0] CMD_in, DATA_in, STA_out, DATA_out;
  logic       busy, done, SCK, SS, MOSI;

  spi_master_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .CMD_in(CMD_in), .DATA_in(DATA_in),
    .STA_out(STA_out), .DATA_out(DATA_out), .busy(busy), .done(done),
    .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO)
  );

  // Back-to-back DUT, CLK_DIV=2, MISO tied low
  logic       rst2, start2;
  logic [7:0] sta2, dout2;
  logic       busy2, done2, sck2, ss2, mosi2;

  spi_master_ctrl #(.CLK_DIV(D2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .CMD_in(8'h5A), .DATA_in(8'hC3),
    .STA_out(sta2), .DATA_out(dout2), .busy(busy2), .done(done2),
    .SCK(sck2), .SS(ss2), .MOSI(mosi2), .MISO(1'b0)
  );

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] sta;
    logic [7:0] dout;
    int         e0;
  } exp_t;
  exp_t sb[$];

  // Slave model: presents word MSB first, advancing after each observed SCK fall.
  logic [15:0] slv_word = '0;
  int   s_falls = 0;
  logic s_psck = 1'b0;
  initial MISO = 1'b0;
  always @(negedge clk) begin
    if (rst || SS) begin
      s_falls = 0;
      MISO    = slv_word[15];
    end else begin
      if (s_psck && !SCK) s_falls++;
      MISO = (s_falls < 16) ? slv_word[15 - s_falls] : 1'b0;
    end
    s_psck = SCK;
  end

  // Monitor for main DUT
  logic [15:0] cap;
  int   rises = 0, done_cnt = 0, exp_bfall = 0;
  logic m_pss = 1'b1, m_psck = 1'b0, m_pbusy = 1'b0, m_pdone = 1'b0, bfall_pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] es, ed;
    if (rst) begin
      m_pss = 1'b1; m_psck = 1'b0; m_pbusy = 1'b0; m_pdone = 1'b0; bfall_pend = 1'b0;
    end else begin
      if (m_pss && !SS) begin cap = '0; rises = 0; end
      if (SCK && !m_psck) begin cap = {cap[14:0], MOSI}; rises++; end
      if (done) begin
        done_cnt++;
        chk("done_one_cycle", {31'd0, m_pdone}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
`ifdef SPI_MASTER_LOOPBACK_EN
          es = e.cmd; ed = e.dat;
`else
          es = e.sta; ed = e.dout;
`endif
          chk("sta_out", {24'd0, STA_out}, {24'd0, es});
          chk("data_out", {24'd0, DATA_out}, {24'd0, ed});
          chk("mosi_bits", {16'd0, cap}, {16'd0, e.cmd, e.dat});
          chk("sck_rises", rises, 16);
          chk("done_time", cyc - e.e0, 34 * D);
          chk("ss_high_at_done", {31'd0, SS}, 32'd1);
          exp_bfall  = e.e0 + 35 * D;
          bfall_pend = 1'b1;
        end
      end
      if (m_pbusy && !busy && bfall_pend) begin
        chk("busy_fall_time", cyc, exp_bfall);
        bfall_pend = 1'b0;
      end
      m_pss = SS; m_psck = SCK; m_pbusy = busy; m_pdone = done;
    end
  end

  // Monitor for back-to-back DUT
  int   n2 = 0, last_fall = 0, last_rise = 0;
  logic p_ss2 = 1'b1, done_since = 1'b0;
  always @(negedge clk) begin
    if (rst2) begin
      p_ss2 = 1'b1; n2 = 0; done_since = 1'b0;
    end else begin
      if (p_ss2 && !ss2) begin
        if (n2 > 0) begin
          chk("b2b_period", cyc - last_fall, 35 * D2 + 1);
          chk("b2b_ss_high_min", {31'd0, (cyc - last_rise) >= 2}, 32'd1);
          chk("b2b_no_overlap", {31'd0, done_since}, 32'd1);
        end
        last_fall  = cyc;
        done_since = 1'b0;
        n2++;
      end
      if (!p_ss2 && ss2) last_rise = cyc;
      if (done2) begin
        done_since = 1'b1;
`ifdef SPI_MASTER_LOOPBACK_EN
        chk("b2b_sta", {24'd0, sta2}, 32'h5A);
        chk("b2b_data", {24'd0, dout2}, 32'hC3);
`else
        chk("b2b_sta", {24'd0, sta2}, 32'h00);
        chk("b2b_data", {24'd0, dout2}, 32'h00);
`endif
      end
      p_ss2 = ss2;
    end
  end

  task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input logic [7:0] sta,
                       input logic [7:0] dout, input bit poke, input bit abort);
    int budget;
    int e0;
    exp_t e;
    budget = 0;
    while (busy && budget < 200) begin @(negedge clk); budget++; end
    CMD_in   = cmd;
    DATA_in  = dat;
    slv_word = {sta, dout};
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    e0      = cyc;
    CMD_in  = 8'($urandom);
    DATA_in = 8'($urandom);
    if (!abort) begin
      e.cmd = cmd; e.dat = dat; e.sta = sta; e.dout = dout; e.e0 = e0;
      sb.push_back(e);
    end
    if (poke) begin
      repeat (20) @(negedge clk);
      CMD_in = 8'hFF;
      start  = 1'b1;
      repeat (3) @(negedge clk);
      start  = 1'b0;
    end
    if (abort) begin
      int dc;
      dc = done_cnt;
      while (cyc < e0 + 50) begin @(posedge clk); #2; end
      rst = 1'b1;
      #1;
      chk("abort_outputs", {28'd0, SS, SCK, MOSI, busy}, 32'b1000);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (40 * D) @(negedge clk);
      chk("abort_no_done", done_cnt, dc);
    end else begin
      budget = 0;
      while ((sb.size() != 0 || busy) && budget < 40 * D) begin @(negedge clk); budget++; end
      chk("frame_complete", {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
    end
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
    CMD_in = '0; DATA_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    start2 = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_state", {13'd0, SS, SCK, MOSI, busy, done, STA_out, DATA_out},
          {13'd0, 5'b10000, 16'h0000});
    end

    frame(8'hA5, 8'h3C, 8'h81, 8'h7E, 1'b0, 1'b0);
    frame(8'h12, 8'h34, 8'hC0, 8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    frame(8'h5A, 8'hC3, 8'h00, 8'hFF, 1'b0, 1'b0);
    frame(8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("b2b_frame_count", {31'd0, n2 >= 4}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
